// File: rtl/lfsr_checker_if.sv
// Sample/status bundle between the LFSR receive path and lfsr_checker.
// The master side drives samples in, and the slave side (the checker) reports status.
interface lfsr_checker_if #(
    parameter int unsigned ERR_W = 8
);
    logic             valid;
    logic [2:0]       rx_data;
    logic             clr_cnt;
    logic             locked;
    logic             err_flag;
    logic [ERR_W-1:0] err_cnt;
    logic             stuck;

    modport master (
        output valid, rx_data, clr_cnt,
        input  locked, err_flag, err_cnt, stuck
    );

    modport slave (
        input  valid, rx_data, clr_cnt,
        output locked, err_flag, err_cnt, stuck
    );
endinterface

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 3-bit XNOR-feedback LFSR stream.
// It hunts for a legal state, verifies LOCK_CNT predictions, then runs a flywheel
// prediction and counts mismatches until LOSS_CNT consecutive misses drop lock.
module lfsr_checker #(
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned LOSS_CNT = 2,
    parameter int unsigned ERR_W    = 8
) (
    input logic          clk,
    input logic          rst,
    lfsr_checker_if.slave bus
);

    typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

    localparam logic [3:0]       LockN  = 4'(LOCK_CNT);
    localparam logic [3:0]       LossN  = 4'(LOSS_CNT);
    localparam logic [ERR_W-1:0] CntOne = ERR_W'(1);

    state_e           state_q, state_d;
    logic [2:0]       exp_q, exp_d;
    logic [2:0]       match_q, match_d;
    logic [2:0]       miss_q, miss_d;
    logic             locked_q, locked_d;
    logic             err_flag_q, err_flag_d;
    logic             stuck_q, stuck_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [3:0] match_inc;
    logic [3:0] miss_inc;
    logic       count_err;
    logic       rx_lockup;

    function automatic logic [2:0] nxt(input logic [2:0] s);
        return {s[1:0], ~(s[2] ^ s[1])};
    endfunction

    assign match_inc = {1'b0, match_q} + 4'd1;
    assign miss_inc  = {1'b0, miss_q} + 4'd1;
    assign rx_lockup = (bus.rx_data == 3'b111);

    // Next-state: acquisition FSM, flywheel prediction and error counter.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        match_d    = match_q;
        miss_d     = miss_q;
        locked_d   = locked_q;
        stuck_d    = stuck_q;
        err_cnt_d  = err_cnt_q;
        err_flag_d = 1'b0;
        count_err  = 1'b0;

        if (bus.valid) begin
            stuck_d = rx_lockup;
            case (state_q)
                StHunt: begin
                    if (!rx_lockup) begin
                        exp_d   = nxt(bus.rx_data);
                        match_d = 3'd0;
                        state_d = StVerify;
                    end
                end
                StVerify: begin
                    if (rx_lockup) begin
                        match_d = 3'd0;
                        state_d = StHunt;
                    end else if (bus.rx_data == exp_q) begin
                        match_d = match_inc[2:0];
                        exp_d   = nxt(bus.rx_data);
                        if (match_inc == LockN) begin
                            state_d  = StLocked;
                            locked_d = 1'b1;
                            miss_d   = 3'd0;
                        end
                    end else begin
                        // Re-seed from the new sample; nothing is counted before lock.
                        exp_d   = nxt(bus.rx_data);
                        match_d = 3'd0;
                    end
                end
                StLocked: begin
                    // Flywheel: prediction advances from itself, never from rx_data.
                    exp_d = nxt(exp_q);
                    if (bus.rx_data == exp_q) begin
                        miss_d = 3'd0;
                    end else begin
                        count_err  = 1'b1;
                        err_flag_d = 1'b1;
                        miss_d     = miss_inc[2:0];
                        if (miss_inc == LossN) begin
                            state_d  = StHunt;
                            locked_d = 1'b0;
                            miss_d   = 3'd0;
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end

        // Clear wins over increment, but a coincident error still counts as one.
        if (bus.clr_cnt) begin
            err_cnt_d = count_err ? CntOne : '0;
        end else if (count_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CntOne;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StHunt;
            exp_q      <= 3'b000;
            match_q    <= 3'd0;
            miss_q     <= 3'd0;
            locked_q   <= 1'b0;
            err_flag_q <= 1'b0;
            stuck_q    <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            locked_q   <= locked_d;
            err_flag_q <= err_flag_d;
            stuck_q    <= stuck_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.locked   = locked_q;
    assign bus.err_flag = err_flag_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.stuck    = stuck_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (default parameters, and ERR_W=4 / LOSS_CNT=7)
// share directed stimulus; a sequence-table model is compared every cycle, and
// hand-computed literals pin the key scenarios.
module tb_lfsr_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [2:0] rx;
    logic       clr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lfsr_checker_if #(.ERR_W(8)) bus_a ();
    lfsr_checker_if #(.ERR_W(4)) bus_b ();

    assign bus_a.valid   = valid;
    assign bus_a.rx_data = rx;
    assign bus_a.clr_cnt = clr;
    assign bus_b.valid   = valid;
    assign bus_b.rx_data = rx;
    assign bus_b.clr_cnt = clr;

    lfsr_checker #(.LOCK_CNT(3), .LOSS_CNT(2), .ERR_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    lfsr_checker #(.LOCK_CNT(3), .LOSS_CNT(7), .ERR_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Model: legal states listed in sequence order; prediction is the table successor.
    typedef struct packed {
        int mode;      // 0 hunt, 1 verify, 2 locked
        int expv;
        int match;
        int miss;
        int locked;
        int err_flag;
        int err_cnt;
        int stuck;
    } mdl_t;

    int seq [7] = '{0, 1, 3, 6, 5, 2, 4};

    mdl_t ma;
    mdl_t mb;

    function automatic int succ(input int v);
        for (int i = 0; i < 7; i++) begin
            if (seq[i] == v) return seq[(i + 1) % 7];
        end
        return -1;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r = '{mode: 0, expv: 0, match: 0, miss: 0, locked: 0, err_flag: 0, err_cnt: 0,
              stuck: 0};
        return r;
    endfunction

    function automatic mdl_t step(input mdl_t m, input int v, input int d, input int c,
                                  input int lock_n, input int loss_n, input int cmax);
        mdl_t r;
        int   err;
        r = m;
        err = 0;
        r.err_flag = 0;
        if (v != 0) begin
            r.stuck = (d == 7) ? 1 : 0;
            if (m.mode == 0) begin
                if (d != 7) begin
                    r.expv = succ(d); r.match = 0; r.mode = 1;
                end
            end else if (m.mode == 1) begin
                if (d == 7) begin
                    r.mode = 0; r.match = 0;
                end else if (d == m.expv) begin
                    r.match = m.match + 1; r.expv = succ(d);
                    if (r.match == lock_n) begin
                        r.mode = 2; r.locked = 1; r.miss = 0;
                    end
                end else begin
                    r.expv = succ(d); r.match = 0;
                end
            end else begin
                r.expv = succ(m.expv);
                if (d == m.expv) begin
                    r.miss = 0;
                end else begin
                    err = 1; r.err_flag = 1; r.miss = m.miss + 1;
                    if (r.miss == loss_n) begin
                        r.mode = 0; r.locked = 0; r.miss = 0;
                    end
                end
            end
        end
        if (c != 0) r.err_cnt = err;
        else if (err != 0 && r.err_cnt < cmax) r.err_cnt = r.err_cnt + 1;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("a_locked",   int'(bus_a.locked),   ma.locked);
            chk("a_err_flag", int'(bus_a.err_flag), ma.err_flag);
            chk("a_err_cnt",  int'(bus_a.err_cnt),  ma.err_cnt);
            chk("a_stuck",    int'(bus_a.stuck),    ma.stuck);
            chk("b_locked",   int'(bus_b.locked),   mb.locked);
            chk("b_err_flag", int'(bus_b.err_flag), mb.err_flag);
            chk("b_err_cnt",  int'(bus_b.err_cnt),  mb.err_cnt);
            chk("b_stuck",    int'(bus_b.stuck),    mb.stuck);
        end
    end

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic send(input bit v, input logic [2:0] d, input bit c);
        valid = v;
        rx    = d;
        clr   = c;
        @(posedge clk);
        ma = step(ma, int'(v), int'(d), int'(c), 3, 2, 255);
        mb = step(mb, int'(v), int'(d), int'(c), 3, 7, 15);
        #1;
    endtask

    task automatic sv(input logic [2:0] d);
        send(1'b1, d, 1'b0);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 3'b111, 1'b0);
    endtask

    // Mid-cycle reset; outputs must clear before any edge.
    task automatic do_reset(input string tag);
        valid = 1'b0;
        clr   = 1'b0;
        rst   = 1'b1;
        #1;
        chk({tag, "_a_locked"},   int'(bus_a.locked),   0);
        chk({tag, "_a_err_flag"}, int'(bus_a.err_flag), 0);
        chk({tag, "_a_err_cnt"},  int'(bus_a.err_cnt),  0);
        chk({tag, "_a_stuck"},    int'(bus_a.stuck),    0);
        chk({tag, "_b_err_cnt"},  int'(bus_b.err_cnt),  0);
        ma = mdl_reset();
        mb = mdl_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic acquire0();
        sv(3'd0); sv(3'd1); sv(3'd3); sv(3'd6);
    endtask

    initial begin
        ma    = mdl_reset();
        mb    = mdl_reset();
        valid = 1'b0;
        rx    = 3'd0;
        clr   = 1'b0;
        do_reset("rst0");

        // Acquire with a gap in the middle of verification.
        sv(3'd0); sv(3'd1);
        gap(2);
        chk("acq_a_stuck_gap", int'(bus_a.stuck), 0);
        sv(3'd3);
        chk("acq_a_locked_3rd", int'(bus_a.locked), 0);
        sv(3'd6);
        chk("acq_a_locked_4th", int'(bus_a.locked), 1);
        chk("acq_model_locked", ma.locked, 1);
        sv(3'd5); sv(3'd2); sv(3'd4); sv(3'd0);
        chk("acq_a_still_locked", int'(bus_a.locked), 1);
        chk("acq_a_err_cnt", int'(bus_a.err_cnt), 0);

        // Single error: 111 replaces 101.
        sv(3'd1); sv(3'd3); sv(3'd6);
        sv(3'd7);
        chk("single_a_err_flag", int'(bus_a.err_flag), 1);
        chk("single_a_err_cnt", int'(bus_a.err_cnt), 1);
        chk("single_a_stuck", int'(bus_a.stuck), 1);
        chk("single_a_locked", int'(bus_a.locked), 1);
        chk("single_model_cnt", ma.err_cnt, 1);
        sv(3'd2);
        chk("single_a_flag_off", int'(bus_a.err_flag), 0);
        chk("single_a_stuck_off", int'(bus_a.stuck), 0);
        chk("single_a_cnt_hold", int'(bus_a.err_cnt), 1);

        // Loss of lock: clear, then two wrong samples where 100, 000 are due.
        send(1'b0, 3'd0, 1'b1);
        chk("clr_alone_a", int'(bus_a.err_cnt), 0);
        sv(3'd1);
        chk("loss_a_locked_1st", int'(bus_a.locked), 1);
        sv(3'd1);
        chk("loss_a_err_cnt", int'(bus_a.err_cnt), 2);
        chk("loss_a_locked_2nd", int'(bus_a.locked), 0);
        chk("loss_a_err_flag", int'(bus_a.err_flag), 1);
        chk("loss_b_locked", int'(bus_b.locked), 1);
        sv(3'd3); sv(3'd6); sv(3'd5);
        chk("relock_a_3rd", int'(bus_a.locked), 0);
        sv(3'd2);
        chk("relock_a_4th", int'(bus_a.locked), 1);

        // Lockup input after a mid-lock reset.
        do_reset("rst1");
        for (int i = 0; i < 10; i++) sv(3'd7);
        chk("lockup_a_locked", int'(bus_a.locked), 0);
        chk("lockup_a_stuck", int'(bus_a.stuck), 1);
        chk("lockup_a_err_cnt", int'(bus_a.err_cnt), 0);
        sv(3'd4); sv(3'd0); sv(3'd1); sv(3'd3);
        chk("lockup_a_relock", int'(bus_a.locked), 1);
        chk("lockup_a_stuck_off", int'(bus_a.stuck), 0);

        // Saturation on the ERR_W=4 / LOSS_CNT=7 instance.
        do_reset("rst2");
        for (int r = 0; r < 3; r++) begin
            acquire0();
            for (int k = 0; k < 7; k++) sv(3'd7);
            if (r == 1) chk("sat_b_cnt_round2", int'(bus_b.err_cnt), 14);
        end
        chk("sat_b_err_cnt", int'(bus_b.err_cnt), 15);
        chk("sat_b_locked", int'(bus_b.locked), 0);
        chk("sat_a_err_cnt", int'(bus_a.err_cnt), 6);
        chk("sat_model_b", mb.err_cnt, 15);

        // Clear with a coincident mismatch, clear alone, then gaps while locked.
        acquire0();
        chk("clr_b_locked", int'(bus_b.locked), 1);
        send(1'b1, 3'd7, 1'b1);
        chk("clr_err_b", int'(bus_b.err_cnt), 1);
        chk("clr_err_a", int'(bus_a.err_cnt), 1);
        send(1'b0, 3'd7, 1'b1);
        chk("clr_only_b", int'(bus_b.err_cnt), 0);
        send(1'b0, 3'd5, 1'b0); send(1'b0, 3'd3, 1'b0); gap(2);
        sv(3'd2);
        gap(3);
        sv(3'd4);
        chk("gap_b_locked", int'(bus_b.locked), 1);
        chk("gap_b_err_cnt", int'(bus_b.err_cnt), 0);
        chk("gap_a_locked", int'(bus_a.locked), 1);
        chk("gap_a_err_cnt", int'(bus_a.err_cnt), 0);
        gap(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 3-bit XNOR-feedback LFSR generator. It samples the generator's 3-bit parallel state stream, self-synchronises to it, and then predicts each following state. Once locked it flags and counts every sample that differs from the prediction. It sits at the far end of the random-sequence path and reports lock status, per-sample errors and a saturating error count to the display/control logic.

## Interface
- LOCK_CNT, 3, consecutive correct predictions needed to declare lock (1..7)
- LOSS_CNT, 2, consecutive mispredictions while locked that drop lock (1..7)
- ERR_W, 8, width of the error counter
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- valid  in  1  rx_data carries a sample this cycle
- rx_data  in  3  received LFSR state
- clr_cnt  in  1  synchronous clear of err_cnt
- locked  out  1  checker is locked to the sequence
- err_flag  out  1  one-cycle pulse, a locked sample mismatched
- err_cnt  out  ERR_W  saturating count of locked mismatches
- stuck  out  1  last valid sample was the lockup value 3'b111

## Operation
- Prediction: nxt(s) = {s[1:0], ~(s[2] ^ s[1])}. The legal cycle is period 7: 000→001→011→110→101→010→100→000. 3'b111 is the lockup state and is never legal.
- Internal registers: state (HUNT/VERIFY/LOCKED), ref[2:0] (expected next sample), match count, miss count.
- No valid: every register holds, and err_flag is 0.
- HUNT, valid, rx≠111: ref←nxt(rx), match←0, go to VERIFY.
- HUNT, valid, rx=111: stay in HUNT.
- VERIFY, valid, rx=ref:
  - match←match+1 and ref←nxt(rx).
  - When match+1 = LOCK_CNT: go to LOCKED, set locked←1, miss←0.
- VERIFY, valid, rx≠ref, rx≠111: ref←nxt(rx), match←0, stay in VERIFY (re-seed, no error counted).
- VERIFY, valid, rx=111: go to HUNT, match←0.
- LOCKED, valid: ref←nxt(ref) on every sample (flywheel: the received data is never used to re-seed).
  - Match: miss←0.
  - Mismatch (111 included): err_flag pulses and err_cnt increments, saturating at 2^ERR_W−1. miss←miss+1.
  - When miss+1 = LOSS_CNT: go to HUNT, set locked←0, miss←0.
- stuck is updated on every valid sample: 1 if rx=111, else 0.
- clr_cnt has priority over increment. clr_cnt together with a counted error gives err_cnt=1. clr_cnt alone gives 0.
- Errors are counted only in LOCKED. HUNT and VERIFY never assert err_flag.

## Timing
- Reset, asynchronous: state=HUNT, ref=000, match=0, miss=0, locked=0, err_flag=0, err_cnt=0, stuck=0. Outputs go to these values immediately, not at the next edge.
- All outputs are registered and reflect the sample presented on the preceding rising edge (1-cycle latency).
- Lock latency: the first valid sample seeds ref. locked rises on the edge that samples the LOCK_CNT-th following correct sample (4 valid samples for the default).
- err_flag is high for exactly one cycle per mismatching valid sample. Back-to-back mismatches give back-to-back pulses.
- The edge on which lock is lost still pulses err_flag and counts the error. locked is 0 in the same cycle that err_flag is 1.
- valid gaps of any length do not advance ref and do not disturb the match or miss counts.
- Reset asserted mid-lock clears everything as above. After release, a full re-acquisition is required.

## Test plan
- Reset check: assert rst, then release. Required: locked=0, err_flag=0, err_cnt=0, stuck=0 before any clock edge.
- Acquire: after reset, feed 000, 001, 011, 110 with valid=1 every cycle. Required: locked=1 after the 4th edge. Continue 101, 010, 100, 000: locked stays 1, err_cnt=0.
- Single error: while locked, expected sequence …110, 101, 010…; send 111 in place of 101, then 010. Required: one err_flag pulse, err_cnt=1, stuck=1 then 0, locked stays 1.
- Loss of lock: while locked, send two consecutive wrong samples. Required: err_cnt=2, locked=0 on the second edge. Resuming with a valid sequence relocks after 4 samples.
- Lockup input: hold rx_data=111 with valid=1 for 10 cycles after reset. Required: locked=0, stuck=1, err_cnt=0. Then feed 100, 000, 001, 011: locked=1.
- Counter edges: with ERR_W=4, force 20 locked mismatches with LOSS_CNT=7 and periodic re-locking. Required: err_cnt saturates at 15. Then assert clr_cnt in the same cycle as a mismatch: err_cnt=1. clr_cnt alone: err_cnt=0. Insert valid=0 gaps mid-sequence: no change in lock or count.
